// File: rtl/serial_receiver.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : serial_receiver
//  Purpose  : Serial-in / parallel-out receiver for the 32-bit serial link.
//             Synchronises the link lines (SerClk, SerBusy, SerIn) into the
//             Clk domain. Samples the data on SerClk falling edges, which fall
//             mid-bit. Deframes an MSB-first SIZE-bit word and presents it on
//             a valid/ack interface. Frame and overrun errors are sticky.
//  Ports    :
//    Clk        in   1      system clock, at least 4x the SerClk frequency
//    Reset      in   1      asynchronous, active-high reset
//    Enable     in   1      1 = new frames may start (looked at in IDLE only)
//    SerClk     in   1      link bit clock; data/envelope change on its rise
//    SerBusy    in   1      link frame envelope
//    SerIn      in   1      link serial data, MSB first
//    DataOut    out  SIZE   last complete received word
//    DataValid  out  1      DataOut holds an unconsumed word
//    DataAck    in   1      consumer accepts DataOut (only while DataValid=1)
//    RxBusy     out  1      frame in progress (SHIFT or WAIT_IDLE)
//    BitCount   out  CNT_W  bits shifted in the current frame
//    FrameErr   out  1      sticky: envelope dropped before SIZE bits
//    Overrun    out  1      sticky: word completed while previous unconsumed
//    ClrErr     in   1      synchronous clear of FrameErr and Overrun
//  Revision : 1.0  initial release
// ============================================================================
module serial_receiver #(
   parameter int SIZE  = 32,
   parameter int CNT_W = $clog2(SIZE + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             SerClk,
   input  logic             SerBusy,
   input  logic             SerIn,
   output logic [SIZE-1:0]  DataOut,
   output logic             DataValid,
   input  logic             DataAck,
   output logic             RxBusy,
   output logic [CNT_W-1:0] BitCount,
   output logic             FrameErr,
   output logic             Overrun,
   input  logic             ClrErr
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SHIFT     = 2'd1,
      ST_WAIT_IDLE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(SIZE - 1);
   localparam logic [CNT_W-1:0] c_FULL     = CNT_W'(SIZE);

   // ------------------------------------------------------------------
   // Synchronisers. All three lines see the same two-stage delay, so a
   // data bit stays aligned with the SerClk edge that frames it.
   // ------------------------------------------------------------------
   logic r_clk_meta, r_clk_sync, r_clk_dly;
   logic r_busy_meta, r_busy_sync, r_busy_dly;
   logic r_in_meta, r_in_sync;

   // Counts the first three cycles after reset. Until it saturates, the
   // synchroniser and delay stages still hold reset zeros rather than
   // line values. Edges seen during that window are artefacts of reset.
   // An example is a frame already in flight when reset was released.
   // These edges are suppressed so that the receiver waits for a genuine
   // rising edge of SerBusy.
   logic [1:0] r_warm;
   logic       w_warm;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_clk_meta  <= 1'b0;
         r_clk_sync  <= 1'b0;
         r_clk_dly   <= 1'b0;
         r_busy_meta <= 1'b0;
         r_busy_sync <= 1'b0;
         r_busy_dly  <= 1'b0;
         r_in_meta   <= 1'b0;
         r_in_sync   <= 1'b0;
         r_warm      <= 2'd0;
      end else begin
         r_clk_meta  <= SerClk;
         r_clk_sync  <= r_clk_meta;
         r_clk_dly   <= r_clk_sync;
         r_busy_meta <= SerBusy;
         r_busy_sync <= r_busy_meta;
         r_busy_dly  <= r_busy_sync;
         r_in_meta   <= SerIn;
         r_in_sync   <= r_in_meta;
         if (r_warm != 2'd3) begin
            r_warm <= r_warm + 2'd1;
         end
      end
   end

   assign w_warm = (r_warm == 2'd3);

   // Sample event: falling edge of the synchronised bit clock (mid-bit).
   logic w_sample;
   logic w_busy_rise;

   assign w_sample    = w_warm & r_clk_dly & ~r_clk_sync;
   assign w_busy_rise = w_warm & r_busy_sync & ~r_busy_dly;

   // ------------------------------------------------------------------
   // Registered state and outputs
   // ------------------------------------------------------------------
   state_t            r_state;
   logic [SIZE-1:0]   r_shreg;
   logic [CNT_W-1:0]  r_bit_count;
   logic [SIZE-1:0]   r_data_out;
   logic              r_data_valid;
   logic              r_rx_busy;
   logic              r_frame_err;
   logic              r_overrun;

   // Next-state values
   state_t            w_state_n;
   logic [SIZE-1:0]   w_shreg_n;
   logic [CNT_W-1:0]  w_bit_count_n;
   logic [SIZE-1:0]   w_data_out_n;
   logic              w_data_valid_n;
   logic              w_rx_busy_n;
   logic              w_frame_err_n;
   logic              w_overrun_n;
   logic              w_frame_err_set;
   logic              w_overrun_set;
   logic              w_complete;
   logic [SIZE-1:0]   w_word;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state      <= ST_IDLE;
         r_shreg      <= '0;
         r_bit_count  <= '0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_rx_busy    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_shreg      <= w_shreg_n;
         r_bit_count  <= w_bit_count_n;
         r_data_out   <= w_data_out_n;
         r_data_valid <= w_data_valid_n;
         r_rx_busy    <= w_rx_busy_n;
         r_frame_err  <= w_frame_err_n;
         r_overrun    <= w_overrun_n;
      end
   end

   always_comb begin
      w_state_n       = r_state;
      w_shreg_n       = r_shreg;
      w_bit_count_n   = r_bit_count;
      w_data_out_n    = r_data_out;
      w_data_valid_n  = r_data_valid;
      w_frame_err_set = 1'b0;
      w_overrun_set   = 1'b0;
      w_complete      = 1'b0;
      // Word as it would look after shifting in the bit currently on the line.
      w_word          = {r_shreg[SIZE-2:0], r_in_sync};

      unique case (r_state)
         ST_IDLE: begin
            if (Enable && w_busy_rise) begin
               w_state_n     = ST_SHIFT;
               w_bit_count_n = '0;
            end
         end

         ST_SHIFT: begin
            // The last bit of a word wins over a concurrent envelope drop.
            // Any other envelope drop while shifting is a frame error.
            if (w_sample && (r_bit_count == c_LAST_BIT)) begin
               w_complete = 1'b1;
               w_shreg_n  = w_word;
               if (r_busy_sync) begin
                  w_state_n     = ST_WAIT_IDLE;
                  w_bit_count_n = c_FULL;
               end else begin
                  w_state_n     = ST_IDLE;
                  w_bit_count_n = '0;
               end
            end else if (!r_busy_sync) begin
               w_frame_err_set = 1'b1;
               w_state_n       = ST_IDLE;
               w_bit_count_n   = '0;
            end else if (w_sample) begin
               w_shreg_n     = w_word;
               w_bit_count_n = r_bit_count + CNT_W'(1);
            end
         end

         ST_WAIT_IDLE: begin
            // The transmitter may clock out a trailing bit. It is ignored
            // until the envelope drops.
            if (!r_busy_sync) begin
               w_state_n     = ST_IDLE;
               w_bit_count_n = '0;
            end
         end

         default: begin
            w_state_n     = ST_IDLE;
            w_bit_count_n = '0;
         end
      endcase

      // Handshake. An ack in the completion cycle frees the slot, so the new
      // word is loaded in that same cycle. Otherwise, a completion with the
      // slot still occupied drops the new word and flags an overrun.
      if (r_data_valid && DataAck) begin
         w_data_valid_n = 1'b0;
      end
      if (w_complete) begin
         if (!r_data_valid || DataAck) begin
            w_data_out_n   = w_word;
            w_data_valid_n = 1'b1;
         end else begin
            w_overrun_set = 1'b1;
         end
      end

      // A set event in the same cycle as ClrErr keeps the flag set.
      w_frame_err_n = w_frame_err_set | (r_frame_err & ~ClrErr);
      w_overrun_n   = w_overrun_set   | (r_overrun   & ~ClrErr);

      w_rx_busy_n   = (w_state_n != ST_IDLE);
   end

   assign DataOut   = r_data_out;
   assign DataValid = r_data_valid;
   assign RxBusy    = r_rx_busy;
   assign BitCount  = r_bit_count;
   assign FrameErr  = r_frame_err;
   assign Overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : tb_serial_receiver
//  Purpose  : Directed testbench for serial_receiver. A link model drives
//             SerClk at 1/8 of Clk. Expected words are queued when a frame is
//             sent. A monitor pops and compares one entry each time the DUT
//             presents a new word.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_receiver;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Enable = 1'b0;
   logic        SerClk = 1'b0;
   logic        SerBusy = 1'b0;
   logic        SerIn = 1'b0;
   logic [31:0] DataOut;
   logic        DataValid;
   logic        DataAck = 1'b0;
   logic        RxBusy;
   logic [5:0]  BitCount;
   logic        FrameErr;
   logic        Overrun;
   logic        ClrErr = 1'b0;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];

   always #5 Clk = ~Clk;

   serial_receiver #(.SIZE(32)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Enable    (Enable),
      .SerClk    (SerClk),
      .SerBusy   (SerBusy),
      .SerIn     (SerIn),
      .DataOut   (DataOut),
      .DataValid (DataValid),
      .DataAck   (DataAck),
      .RxBusy    (RxBusy),
      .BitCount  (BitCount),
      .FrameErr  (FrameErr),
      .Overrun   (Overrun),
      .ClrErr    (ClrErr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] dout, input logic valid,
                                input logic busy, input logic [5:0] cnt,
                                input logic ferr, input logic ovr);
      check({tag, "_DataOut"},   DataOut,   dout);
      check({tag, "_DataValid"}, {31'd0, DataValid}, {31'd0, valid});
      check({tag, "_RxBusy"},    {31'd0, RxBusy},    {31'd0, busy});
      check({tag, "_BitCount"},  {26'd0, BitCount},  {26'd0, cnt});
      check({tag, "_FrameErr"},  {31'd0, FrameErr},  {31'd0, ferr});
      check({tag, "_Overrun"},   {31'd0, Overrun},   {31'd0, ovr});
   endtask

   // Link model. Each bit lasts 8 Clk cycles: SerClk is high for 4 and low
   // for 4, and all line changes happen at Clk negedges. When ack_last is
   // set, DataAck is raised for exactly the Clk cycle in which the receiver
   // acts on the final sample. That sample is resolved on the third Clk
   // posedge after SerClk falls: two synchroniser stages plus the edge
   // detector.
   task automatic send_frame(input logic [31:0] w, input int nbits, input bit trailing,
                             input bit ack_last, input bit drop);
      int total;
      total = nbits + (trailing ? 1 : 0);
      @(negedge Clk);
      for (int i = 0; i < total; i++) begin
         SerClk  = 1'b1;
         SerBusy = 1'b1;
         SerIn   = (i < nbits) ? w[31-i] : 1'b1;
         repeat (4) @(negedge Clk);
         SerClk = 1'b0;
         @(posedge Clk);
         @(posedge Clk);
         #1;
         if (ack_last && (i == nbits - 1)) DataAck = 1'b1;
         @(posedge Clk);
         #1;
         if (ack_last && (i == nbits - 1)) DataAck = 1'b0;
         @(negedge Clk);
         @(negedge Clk);
      end
      if (drop) begin
         SerClk  = 1'b1;
         SerBusy = 1'b0;
         SerIn   = 1'b0;
         repeat (4) @(negedge Clk);
         SerClk = 1'b0;
         repeat (12) @(negedge Clk);
      end
   endtask

   task automatic pulse_ack();
      @(posedge Clk);
      #1 DataAck = 1'b1;
      @(posedge Clk);
      #1 DataAck = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge Clk);
      #1 ClrErr = 1'b1;
      @(posedge Clk);
      #1 ClrErr = 1'b0;
   endtask

   // Scoreboard monitor. A new word is presented when DataValid rises, or
   // when DataValid stays high across a cycle in which it was acknowledged.
   initial begin : monitor
      logic prev_valid;
      logic prev_ack;
      prev_valid = 1'b0;
      prev_ack   = 1'b0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
         end else begin
            if (DataValid && (!prev_valid || prev_ack)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected_word actual=0x%08h required=none", DataOut);
               end else begin
                  check("sb_word", DataOut, exp_q.pop_front());
               end
            end
            prev_valid = DataValid;
            prev_ack   = DataAck;
         end
      end
   end

   initial begin : stimulus
      // T1: reset held while the inputs toggle randomly.
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         Enable  = 1'($urandom_range(0, 1));
         SerClk  = 1'($urandom_range(0, 1));
         SerBusy = 1'($urandom_range(0, 1));
         SerIn   = 1'($urandom_range(0, 1));
         DataAck = 1'($urandom_range(0, 1));
         ClrErr  = 1'($urandom_range(0, 1));
      end
      check_outputs("t1_in_reset", 32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      @(negedge Clk);
      Enable = 1'b1; SerClk = 1'b0; SerBusy = 1'b0; SerIn = 1'b0;
      DataAck = 1'b0; ClrErr = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      repeat (20) @(negedge Clk);
      check_outputs("t1_idle", 32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);

      // T2: basic word with a trailing bit. The word is held until acked.
      exp_q.push_back(32'hA5C30F81);
      send_frame(32'hA5C30F81, 32, 1'b1, 1'b0, 1'b1);
      repeat (5) @(negedge Clk);
      check_outputs("t2_word", 32'hA5C30F81, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      pulse_ack();
      check("t2_valid_after_ack", {31'd0, DataValid}, 32'd0);

      // T3: overrun. The second word is dropped and the first is kept.
      exp_q.push_back(32'h12345678);
      send_frame(32'h12345678, 32, 1'b0, 1'b0, 1'b1);
      send_frame(32'hDEADBEEF, 32, 1'b0, 1'b0, 1'b1);
      check_outputs("t3_overrun", 32'h12345678, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
      pulse_clr();
      check("t3_overrun_cleared", {31'd0, Overrun}, 32'd0);
      pulse_ack();

      // T4: frame error after 10 bits, then a good frame.
      send_frame(32'hCAFEBABE, 10, 1'b0, 1'b0, 1'b1);
      check_outputs("t4_frame_err", 32'h12345678, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
      exp_q.push_back(32'hFFFF0000);
      send_frame(32'hFFFF0000, 32, 1'b0, 1'b0, 1'b1);
      check_outputs("t4_next_word", 32'hFFFF0000, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
      pulse_clr();
      pulse_ack();
      check("t4_ferr_cleared", {31'd0, FrameErr}, 32'd0);

      // T5: ack lands exactly on the completion cycle of the second word.
      exp_q.push_back(32'h00FF00FF);
      send_frame(32'h00FF00FF, 32, 1'b0, 1'b0, 1'b1);
      exp_q.push_back(32'h0000FFFF);
      send_frame(32'h0000FFFF, 32, 1'b0, 1'b1, 1'b1);
      check_outputs("t5_collision", 32'h0000FFFF, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      pulse_ack();

      // T6: reset after 16 bits, with the envelope still high afterwards.
      send_frame(32'h13579BDF, 16, 1'b0, 1'b0, 1'b0);
      check("t6_bitcount_mid", {26'd0, BitCount}, 32'd16);
      check("t6_rxbusy_mid", {31'd0, RxBusy}, 32'd1);
      #2 Reset = 1'b1;
      #1;
      check_outputs("t6_reset", 32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      // The rest of the interrupted frame must not start a new reception.
      send_frame(32'hF0F0F0F0, 8, 1'b0, 1'b0, 1'b1);
      check_outputs("t6_no_restart", 32'h0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      exp_q.push_back(32'h80000001);
      send_frame(32'h80000001, 32, 1'b0, 1'b0, 1'b1);
      check_outputs("t6_next_word", 32'h80000001, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      pulse_ack();

      repeat (4) @(negedge Clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
